// File: rtl/zero_detect_scheduler_if.sv
// Channel-side and detector-side signals of the shared zero-detector scheduler.
// master = channel front-ends plus detector, slave = scheduler.
interface zero_detect_scheduler_if #(
    parameter int unsigned N_CH      = 4,
    parameter int unsigned FRAME_LEN = 8
);
    localparam int unsigned CH_W  = $clog2(N_CH);
    localparam int unsigned CNT_W = $clog2(FRAME_LEN + 1);

    logic [N_CH-1:0]           req;
    logic [N_CH*FRAME_LEN-1:0] data;
    logic [N_CH-1:0]           ack;
    logic                      det_x_in;
    logic                      det_reset;
    logic                      det_y_out;
    logic                      busy;
    logic                      done;
    logic [CH_W-1:0]           done_ch;
    logic [CNT_W-1:0]          zero_cnt;

    modport master (
        output req, data, det_y_out,
        input  ack, det_x_in, det_reset, busy, done, done_ch, zero_cnt
    );

    modport slave (
        input  req, data, det_y_out,
        output ack, det_x_in, det_reset, busy, done, done_ch, zero_cnt
    );
endinterface

// File: rtl/zero_detect_scheduler.sv
// Round-robin scheduler sharing one Mealy zero-detector between N_CH channels:
// grants a channel, clears the detector, streams its word MSB-first and counts y_out pulses.
module zero_detect_scheduler #(
    parameter int unsigned N_CH      = 4,
    parameter int unsigned FRAME_LEN = 8
) (
    input  logic                      clock,
    input  logic                      reset,
    zero_detect_scheduler_if.slave    bus
);
    localparam int unsigned CH_W  = $clog2(N_CH);
    localparam int unsigned CNT_W = $clog2(FRAME_LEN + 1);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] CLEAR  = 2'd1;
    localparam logic [1:0] SHIFT  = 2'd2;
    localparam logic [1:0] REPORT = 2'd3;

    logic [1:0]           state,      state_nxt;
    logic [FRAME_LEN-1:0] shreg,      shreg_nxt;
    logic [CNT_W-1:0]     bit_idx,    bit_idx_nxt;
    logic [CNT_W-1:0]     acc,        acc_nxt;
    logic [CH_W-1:0]      rr_ptr,     rr_ptr_nxt;
    logic [CH_W-1:0]      cur_ch,     cur_ch_nxt;
    logic [N_CH-1:0]      ack_q,      ack_nxt;
    logic                 det_x_q,    det_x_nxt;
    logic                 det_rst_q,  det_rst_nxt;
    logic                 busy_q,     busy_nxt;
    logic                 done_q,     done_nxt;
    logic [CH_W-1:0]      done_ch_q,  done_ch_nxt;
    logic [CNT_W-1:0]     zero_cnt_q, zero_cnt_nxt;

    logic                 grant_vld;
    logic [CH_W-1:0]      grant_ch;
    logic [FRAME_LEN-1:0] grant_word;

    // First requester at or after rr_ptr, wrapping modulo N_CH.
    always_comb begin
        grant_vld = 1'b0;
        grant_ch  = '0;
        for (int unsigned off = 0; off < N_CH; off++) begin
            if (!grant_vld && bus.req[CH_W'((32'(rr_ptr) + off) % N_CH)]) begin
                grant_vld = 1'b1;
                grant_ch  = CH_W'((32'(rr_ptr) + off) % N_CH);
            end
        end
    end

    assign grant_word = FRAME_LEN'(bus.data >> (32'(grant_ch) * FRAME_LEN));

    always_ff @(posedge clock) begin
        if (!reset) begin
            state      <= IDLE;
            shreg      <= '0;
            bit_idx    <= '0;
            acc        <= '0;
            rr_ptr     <= '0;
            cur_ch     <= '0;
            ack_q      <= '0;
            det_x_q    <= 1'b1;
            det_rst_q  <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            done_ch_q  <= '0;
            zero_cnt_q <= '0;
        end else begin
            state      <= state_nxt;
            shreg      <= shreg_nxt;
            bit_idx    <= bit_idx_nxt;
            acc        <= acc_nxt;
            rr_ptr     <= rr_ptr_nxt;
            cur_ch     <= cur_ch_nxt;
            ack_q      <= ack_nxt;
            det_x_q    <= det_x_nxt;
            det_rst_q  <= det_rst_nxt;
            busy_q     <= busy_nxt;
            done_q     <= done_nxt;
            done_ch_q  <= done_ch_nxt;
            zero_cnt_q <= zero_cnt_nxt;
        end
    end

    // Next state and next registered outputs; ack and done are single-cycle pulses.
    always_comb begin
        state_nxt    = state;
        shreg_nxt    = shreg;
        bit_idx_nxt  = bit_idx;
        acc_nxt      = acc;
        rr_ptr_nxt   = rr_ptr;
        cur_ch_nxt   = cur_ch;
        ack_nxt      = '0;
        det_x_nxt    = det_x_q;
        det_rst_nxt  = det_rst_q;
        busy_nxt     = busy_q;
        done_nxt     = 1'b0;
        done_ch_nxt  = done_ch_q;
        zero_cnt_nxt = zero_cnt_q;

        case (state)
            IDLE: begin
                det_x_nxt   = 1'b1;
                det_rst_nxt = 1'b0;
                if (grant_vld) begin
                    shreg_nxt   = grant_word;
                    cur_ch_nxt  = grant_ch;
                    bit_idx_nxt = '0;
                    acc_nxt     = '0;
                    rr_ptr_nxt  = (grant_ch == CH_W'(N_CH - 1)) ? '0 : grant_ch + 1'b1;
                    ack_nxt     = N_CH'(1) << grant_ch;
                    busy_nxt    = 1'b1;
                    state_nxt   = CLEAR;
                end
            end
            CLEAR: begin
                det_rst_nxt = 1'b1;
                det_x_nxt   = shreg[FRAME_LEN-1];
                shreg_nxt   = {shreg[FRAME_LEN-2:0], 1'b0};
                state_nxt   = SHIFT;
            end
            SHIFT: begin
                acc_nxt = acc + CNT_W'(bus.det_y_out);
                if (bit_idx == CNT_W'(FRAME_LEN - 1)) begin
                    done_nxt     = 1'b1;
                    done_ch_nxt  = cur_ch;
                    zero_cnt_nxt = acc + CNT_W'(bus.det_y_out);
                    det_rst_nxt  = 1'b0;
                    det_x_nxt    = 1'b1;
                    state_nxt    = REPORT;
                end else begin
                    det_x_nxt   = shreg[FRAME_LEN-1];
                    shreg_nxt   = {shreg[FRAME_LEN-2:0], 1'b0};
                    bit_idx_nxt = bit_idx + 1'b1;
                end
            end
            REPORT: begin
                busy_nxt  = 1'b0;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign bus.ack       = ack_q;
    assign bus.det_x_in  = det_x_q;
    assign bus.det_reset = det_rst_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.done_ch   = done_ch_q;
    assign bus.zero_cnt  = zero_cnt_q;
endmodule
